// File: rtl/interval_timer_if.sv
// Load/control/status bundle for interval_timer: load handshake, tick qualifier,
// abort/acknowledge controls and count/expire/busy/done status.
interface interval_timer_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             load_periodic;
    logic             stop;
    logic             done_ack;
    logic [WIDTH-1:0] cnt;
    logic             expire;
    logic             busy;
    logic             done;

    modport master (
        output enable, load_valid, load_value, load_periodic, stop, done_ack,
        input  load_ready, cnt, expire, busy, done
    );

    modport slave (
        input  enable, load_valid, load_value, load_periodic, stop, done_ack,
        output load_ready, cnt, expire, busy, done
    );
endinterface

// File: rtl/interval_timer.sv
// Loadable down-counting interval timer with one-shot and auto-reload modes.
// Expire is a registered one-cycle strobe issued the cycle after the terminal tick.
module interval_timer #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    interval_timer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic             expire_q, expire_d;
    logic             load_fire;

    // Only called when cnt is non-zero, so the subtraction never wraps.
    function automatic logic [WIDTH-1:0] dec_cnt(input logic [WIDTH-1:0] v);
        return v - WIDTH'(1);
    endfunction

    assign bus.load_ready = !reset && (state_q != RUN);
    assign load_fire      = bus.load_valid && bus.load_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        expire_d   = 1'b0;
        if (load_fire) begin
            // A load outranks stop and done_ack presented in the same cycle.
            state_d    = RUN;
            cnt_d      = bus.load_value;
            reload_d   = bus.load_value;
            periodic_d = bus.load_periodic;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (bus.enable) begin
                        if (cnt_q == '0) begin
                            expire_d = 1'b1;
                            if (periodic_q) cnt_d = reload_q;
                            else            state_d = DONE;
                        end else begin
                            cnt_d = dec_cnt(cnt_q);
                        end
                    end
                end
                DONE: begin
                    if (bus.stop || bus.done_ack) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            expire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            expire_q   <= expire_d;
        end
    end

    assign bus.cnt    = cnt_q;
    assign bus.expire = expire_q;
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
endmodule
